pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Sequential controller that owns the program counter and drives the single-cycle fetch stage.
- Holds PC, selects the next PC from fetch/execute/memory results, and gates fetching.
- Tracks the Y86 status code (AOK/HLT/ADR/INS) and stops on halt or error.
- Sits between the fetch stage (PC out; icode/valC/valP/error in) and the execute/memory stages (cnd, valM, dmem error).

Parameters:
- PC_W, 64, PC and address width
- RESET_PC, 0, PC loaded on reset and on start
- CNT_W, 32, width of the cycle and retire counters

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- start_i  in  1  1-cycle pulse: begin or restart execution at RESET_PC
- stall_i  in  1  hold the current instruction; no commit this cycle
- icode_i  in  4  from fetch
- valC_i  in  PC_W  from fetch
- valP_i  in  PC_W  from fetch
- instr_valid_i  in  1  from fetch
- imem_error_i  in  1  from fetch
- cnd_i  in  1  branch condition from execute
- valM_i  in  PC_W  return address read by memory
- dmem_error_i  in  1  data memory address error
- PC_o  out  PC_W  current fetch address
- fetch_en_o  out  1  fetch outputs are meaningful and may commit
- retire_o  out  1  pulse: instruction committed this cycle
- stat_o  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS
- cycle_cnt_o  out  CNT_W  cycles spent in RUN
- instr_cnt_o  out  CNT_W  committed instruction count

Behaviour:
- Clock is clk_i. Reset is rst_n_i: asynchronous, active-low. This is already decided.
- Reset values: state=IDLE, PC_o=RESET_PC, fetch_en_o=0, retire_o=0, stat_o=AOK, both counters=0.
- States:
  - IDLE: fetch_en_o=0. start_i -> RUN with PC=RESET_PC.
  - RUN: fetch_en_o=1. cycle_cnt_o increments every RUN cycle, including stalled cycles.
  - HALT: fetch_en_o=0, stat_o=HLT.
  - ERR: fetch_en_o=0, stat_o=ADR or INS.
- Commit condition: state==RUN and stall_i==0. On commit, evaluate in priority order:
  1. imem_error_i -> ERR, stat=ADR
  2. !instr_valid_i -> ERR, stat=INS
  3. dmem_error_i -> ERR, stat=ADR
  4. icode_i==IHALT -> HALT, stat=HLT
  5. otherwise PC <= next PC, retire_o=1 for one cycle, instr_cnt_o+1
- On cases 1–4, PC holds (it points at the faulting or halting instruction) and retire_o=0.
- Next PC:
  - ICALL -> valC_i
  - IJXX with cnd_i=1 -> valC_i
  - IRET -> valM_i
  - all else (including IJXX with cnd_i=0) -> valP_i
- PC updates take effect one cycle after commit. Both counters wrap silently at 2^CNT_W.
- stall_i=1 in RUN: PC, stat and instr_cnt hold; retire_o=0. stall_i is ignored outside RUN.
- start_i behaviour:
  - Ignored in RUN.
  - From HALT or ERR -> RUN: PC=RESET_PC, stat=AOK, counters cleared.
  - start_i and stall_i in the same cycle: start wins; stall applies from the next cycle.
- Reset asserted mid-run returns immediately to the reset values regardless of state.

Optional Feature:
- Macro: PC_BREAKPOINT_EN.
- When defined:
  - Adds ports bp_en_i (in, 1), bp_addr_i (in, PC_W) and brk_o (out, 1), plus state BRK.
  - In RUN, a commit attempt with bp_en_i=1 and PC_o==bp_addr_i goes to BRK instead: no commit, fetch_en_o=0, brk_o=1, stat stays AOK, counters frozen.
  - start_i in BRK returns to RUN at the same PC with counters kept. The breakpoint is suppressed for that first commit so execution progresses.
  - Error and halt checks take priority over the breakpoint.
- When undefined: none of these ports or the BRK state exist.

Decomposition:
- define.v holds the icode constants (IHALT, IJXX, ICALL, IRET, ...), the new stat constants SAOK=1, SHLT=2, SADR=3, SINS=4, and the state encodings.
- One sub-module, pc_next_sel: purely combinational next-PC mux (icode, cnd, valC, valP, valM -> next PC).
- Counters and the FSM live in pc_sequencer.

Test Plan:
- Reset, then start. Drive icode=3, valP=10 for one cycle, then icode=3, valP=20 -> PC_o sequence 0, 10, 20; retire_o pulses twice; instr_cnt_o=2.
- At PC=20, drive icode=7, valC=0x40, valP=29:
  - cnd=1 -> PC_o=0x40
  - repeat with cnd=0 -> PC_o=29
  - icode=8 (call), valC=0x80 -> PC_o=0x80
  - icode=9 (ret), valM=0x2A -> PC_o=0x2A
- stall_i=1 for 3 cycles mid-run -> PC_o and instr_cnt_o constant, cycle_cnt_o +3, retire_o=0.
- icode=0 at PC=0x30 -> stat_o=2, fetch_en_o=0, PC_o stays 0x30. Then start_i -> PC_o=0, stat_o=1, counters 0.
- Error priority:
  - imem_error_i=1 together with instr_valid_i=0 -> stat_o=3
  - instr_valid_i=0 alone -> stat_o=4
  - reset pulse while in ERR -> stat_o=1, state IDLE.
- PC_BREAKPOINT_EN: bp_addr=10, bp_en=1 -> brk_o=1 with PC_o=10. start_i -> instruction at 10 commits, PC_o=20, brk_o=0.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: Y86 instruction codes, status codes and sequencer states.
// The BRK state exists only when PC_BREAKPOINT_EN is defined.
package pc_sequencer_pkg;
   localparam logic [3:0] IHALT = 4'h0, INOP = 4'h1, IRRMOVQ = 4'h2, IIRMOVQ = 4'h3,
                          IRMMOVQ = 4'h4, IMRMOVQ = 4'h5, IOPQ = 4'h6, IJXX = 4'h7,
                          ICALL = 4'h8, IRET = 4'h9, IPUSHQ = 4'hA, IPOPQ = 4'hB;
   localparam logic [2:0] SAOK = 3'd1, SHLT = 3'd2, SADR = 3'd3, SINS = 3'd4;
   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_HALT,
      S_ERR
`ifdef PC_BREAKPOINT_EN
      , S_BRK
`endif
   } state_t;
endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel: combinational next-PC select from fetch, execute and memory results.
module pc_next_sel
   import pc_sequencer_pkg::*;
#(
   parameter int PC_W = 64
) (
   input  logic [3:0]      icode,
   input  logic            cnd,
   input  logic [PC_W-1:0] val_c,
   input  logic [PC_W-1:0] val_p,
   input  logic [PC_W-1:0] val_m,
   output logic [PC_W-1:0] next_pc
);
   assign next_pc = (icode == ICALL || (icode == IJXX && cnd)) ? val_c :
                    icode == IRET ? val_m : val_p;
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the Y86 PC, gates fetch, tracks status and counts cycles/retires.
// Optional breakpoint support (bp_en_i/bp_addr_i/brk_o, BRK state) under PC_BREAKPOINT_EN.
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter int              PC_W     = 64,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter int              CNT_W    = 32
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             start_i,
   input  logic             stall_i,
   input  logic [3:0]       icode_i,
   input  logic [PC_W-1:0]  valC_i,
   input  logic [PC_W-1:0]  valP_i,
   input  logic             instr_valid_i,
   input  logic             imem_error_i,
   input  logic             cnd_i,
   input  logic [PC_W-1:0]  valM_i,
   input  logic             dmem_error_i,
`ifdef PC_BREAKPOINT_EN
   input  logic             bp_en_i,
   input  logic [PC_W-1:0]  bp_addr_i,
   output logic             brk_o,
`endif
   output logic [PC_W-1:0]  PC_o,
   output logic             fetch_en_o,
   output logic             retire_o,
   output logic [2:0]       stat_o,
   output logic [CNT_W-1:0] cycle_cnt_o,
   output logic [CNT_W-1:0] instr_cnt_o
);
   state_t           state, state_d;
   logic [PC_W-1:0]  pc_d, next_pc;
   logic [2:0]       stat_d, fault;
   logic [CNT_W-1:0] cyc_d, ins_d;
   logic             commit;
`ifdef PC_BREAKPOINT_EN
   logic             bp_skip, skip_d;
`endif

   pc_next_sel #(.PC_W(PC_W)) u_next (
      .icode   (icode_i),
      .cnd     (cnd_i),
      .val_c   (valC_i),
      .val_p   (valP_i),
      .val_m   (valM_i),
      .next_pc (next_pc)
   );

   assign fetch_en_o = state == S_RUN;
`ifdef PC_BREAKPOINT_EN
   assign brk_o = state == S_BRK;
`endif

   always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i) begin
         state       <= S_IDLE;
         PC_o        <= RESET_PC;
         stat_o      <= SAOK;
         cycle_cnt_o <= '0;
         instr_cnt_o <= '0;
      end else begin
         state       <= state_d;
         PC_o        <= pc_d;
         stat_o      <= stat_d;
         cycle_cnt_o <= cyc_d;
         instr_cnt_o <= ins_d;
      end

`ifdef PC_BREAKPOINT_EN
   always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i) bp_skip <= 1'b0;
      else bp_skip <= skip_d;
`endif

   // Fault priority: fetch address, invalid instruction, data address, then halt.
   always_comb begin
      state_d  = state;
      pc_d     = PC_o;
      stat_d   = stat_o;
      cyc_d    = cycle_cnt_o;
      ins_d    = instr_cnt_o;
      retire_o = 1'b0;
`ifdef PC_BREAKPOINT_EN
      skip_d   = bp_skip;
`endif
      commit = state == S_RUN && !stall_i;
      fault  = imem_error_i ? SADR : !instr_valid_i ? SINS : dmem_error_i ? SADR :
               icode_i == IHALT ? SHLT : SAOK;
      if (state == S_RUN) cyc_d = cycle_cnt_o + CNT_W'(1);
      if (commit) begin
         if (fault != SAOK) begin
            state_d = fault == SHLT ? S_HALT : S_ERR;
            stat_d  = fault;
         end
`ifdef PC_BREAKPOINT_EN
         else if (bp_en_i && PC_o == bp_addr_i && !bp_skip) state_d = S_BRK;
`endif
         else begin
            pc_d     = next_pc;
            retire_o = 1'b1;
            ins_d    = instr_cnt_o + CNT_W'(1);
         end
`ifdef PC_BREAKPOINT_EN
         skip_d = 1'b0;
`endif
      end
`ifdef PC_BREAKPOINT_EN
      else if (state == S_BRK && start_i) begin
         state_d = S_RUN;
         skip_d  = 1'b1;
      end
`endif
      else if (state != S_RUN && start_i) begin
         state_d = S_RUN;
         pc_d    = RESET_PC;
         stat_d  = SAOK;
         cyc_d   = '0;
         ins_d   = '0;
      end
   end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: vector table, directed corner cases and a randomized reference-model run.
// Breakpoint checks are compiled in when PC_BREAKPOINT_EN is defined.
module tb_pc_sequencer;
   localparam int PC_W  = 64;
   localparam int CNT_W = 4;

   typedef struct {
      logic [3:0]  icode;
      logic [63:0] valc, valp, valm;
      logic        cnd, valid, imem, dmem, stall, start;
   } in_t;

   typedef struct {
      in_t         i;
      logic [63:0] pc;
      logic        ret;
      logic [3:0]  cyc, ins;
   } vec_t;

   logic             clk = 1'b0, rst_n = 1'b0, start = 1'b0, stall = 1'b0;
   logic             cnd = 1'b0, valid = 1'b1, imem = 1'b0, dmem = 1'b0;
   logic [3:0]       icode = 4'h1;
   logic [PC_W-1:0]  valc = '0, valp = '0, valm = '0;
   logic [PC_W-1:0]  pc;
   logic             fetch_en, retire;
   logic [2:0]       stat;
   logic [CNT_W-1:0] cyc, ins;
`ifdef PC_BREAKPOINT_EN
   logic             bp_en = 1'b0, brk;
   logic [PC_W-1:0]  bp_addr = '0;
`endif
   int total = 0, passed = 0;

   pc_sequencer #(.PC_W(PC_W), .RESET_PC('0), .CNT_W(CNT_W)) dut (
      .clk_i         (clk),
      .rst_n_i       (rst_n),
      .start_i       (start),
      .stall_i       (stall),
      .icode_i       (icode),
      .valC_i        (valc),
      .valP_i        (valp),
      .instr_valid_i (valid),
      .imem_error_i  (imem),
      .cnd_i         (cnd),
      .valM_i        (valm),
      .dmem_error_i  (dmem),
`ifdef PC_BREAKPOINT_EN
      .bp_en_i       (bp_en),
      .bp_addr_i     (bp_addr),
      .brk_o         (brk),
`endif
      .PC_o          (pc),
      .fetch_en_o    (fetch_en),
      .retire_o      (retire),
      .stat_o        (stat),
      .cycle_cnt_o   (cyc),
      .instr_cnt_o   (ins)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic in_t mk(input logic [3:0] ic, input logic [63:0] c, p, m,
                              input logic cn, input logic st);
      in_t v;
      v.icode = ic; v.valc = c; v.valp = p; v.valm = m; v.cnd = cn;
      v.valid = 1'b1; v.imem = 1'b0; v.dmem = 1'b0; v.stall = st; v.start = 1'b0;
      return v;
   endfunction

   // Drive one cycle; r is retire_o sampled mid-cycle, state is sampled 1 after the edge.
   task automatic apply(input in_t v, output logic r);
      icode = v.icode; valc = v.valc; valp = v.valp; valm = v.valm; cnd = v.cnd;
      valid = v.valid; imem = v.imem; dmem = v.dmem; stall = v.stall; start = v.start;
      @(negedge clk);
      r = retire;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic do_start();
      in_t  v;
      logic r;
      v = mk(4'h1, 0, 0, 0, 0, 0);
      v.start = 1'b1;
      apply(v, r);
   endtask

   vec_t       vt[10];
   in_t        v;
   logic       r, exp_r, m_run;
   logic [63:0] m_pc;
   logic [2:0] m_stat, f;
   logic [3:0] m_cyc, m_ins;

   initial begin
      vt[0] = '{mk(4'h3, 0, 10, 0, 0, 0), 10, 1, 1, 1};
      vt[1] = '{mk(4'h3, 0, 20, 0, 0, 0), 20, 1, 2, 2};
      vt[2] = '{mk(4'h7, 64'h40, 29, 0, 1, 0), 64'h40, 1, 3, 3};
      vt[3] = '{mk(4'h7, 64'h40, 29, 0, 0, 0), 29, 1, 4, 4};
      vt[4] = '{mk(4'h8, 64'h80, 38, 0, 1, 0), 64'h80, 1, 5, 5};
      vt[5] = '{mk(4'h9, 64'h55, 64'h81, 64'h2A, 1, 0), 64'h2A, 1, 6, 6};
      vt[6] = '{mk(4'h3, 64'h99, 64'h99, 64'h99, 1, 1), 64'h2A, 0, 7, 6};
      vt[7] = '{mk(4'h8, 64'h99, 64'h99, 64'h99, 1, 1), 64'h2A, 0, 8, 6};
      vt[8] = '{mk(4'h9, 64'h99, 64'h99, 64'h99, 1, 1), 64'h2A, 0, 9, 6};
      vt[9] = '{mk(4'h6, 0, 64'h30, 0, 0, 0), 64'h30, 1, 10, 7};

      repeat (2) @(posedge clk);
      #1;
      check("reset pc", pc, 0);
      check("reset fetch_en", fetch_en, 0);
      check("reset retire", retire, 0);
      check("reset stat", stat, 1);
      check("reset cycle_cnt", cyc, 0);
      check("reset instr_cnt", ins, 0);
      rst_n = 1'b1;

      do_start();
      check("start pc", pc, 0);
      check("start fetch_en", fetch_en, 1);

      foreach (vt[k]) begin
         apply(vt[k].i, r);
         check($sformatf("vec%0d pc", k), pc, vt[k].pc);
         check($sformatf("vec%0d retire", k), r, vt[k].ret);
         check($sformatf("vec%0d counts", k), {cyc, ins}, {vt[k].cyc, vt[k].ins});
      end

      apply(mk(4'h0, 0, 64'h31, 0, 0, 0), r);
      check("halt retire", r, 0);
      check("halt stat", stat, 2);
      check("halt fetch_en", fetch_en, 0);
      check("halt pc", pc, 64'h30);
      check("halt counts", {cyc, ins}, {4'd11, 4'd7});
      apply(mk(4'h3, 0, 64'h50, 0, 0, 1), r);
      check("stall outside run", {stat, cyc, pc}, {3'd2, 4'd11, 64'h30});

      v = mk(4'h3, 0, 5, 0, 0, 1);
      v.start = 1'b1;
      apply(v, r);
      check("start+stall pc", pc, 0);
      check("start+stall state", {stat, fetch_en, cyc, ins}, {3'd1, 1'b1, 4'd0, 4'd0});
      apply(mk(4'h3, 0, 5, 0, 0, 1), r);
      check("stall after start", {pc, r, cyc}, {64'h0, 1'b0, 4'd1});
      v = mk(4'h3, 0, 64'h11, 0, 0, 0);
      v.start = 1'b1;
      apply(v, r);
      check("start ignored in run", {pc, r, cyc, ins}, {64'h11, 1'b1, 4'd2, 4'd1});

      v = mk(4'h3, 0, 64'h12, 0, 0, 0);
      v.imem = 1'b1; v.valid = 1'b0;
      apply(v, r);
      check("imem+invalid stat", stat, 3);
      check("imem err hold", {pc, r, fetch_en}, {64'h11, 1'b0, 1'b0});
      do_start();
      v = mk(4'h3, 0, 64'h12, 0, 0, 0);
      v.valid = 1'b0;
      apply(v, r);
      check("invalid stat", stat, 4);
      do_start();
      v = mk(4'h0, 0, 64'h12, 0, 0, 0);
      v.dmem = 1'b1;
      apply(v, r);
      check("dmem over halt stat", stat, 3);
      rst_n = 1'b0;
      #2;
      check("async reset in err", {stat, fetch_en, pc}, {3'd1, 1'b0, 64'h0});
      rst_n = 1'b1;

      m_run = 0; m_pc = 0; m_stat = 1; m_cyc = 0; m_ins = 0;
      for (int n = 0; n < 600; n++) begin
         v.icode = ($urandom_range(0, 15) == 0) ? 4'h0 : 4'($urandom_range(1, 11));
         v.valc = {$urandom, $urandom}; v.valp = {$urandom, $urandom}; v.valm = {$urandom, $urandom};
         v.cnd = 1'($urandom);
         v.valid = $urandom_range(0, 24) != 0;
         v.imem = $urandom_range(0, 29) == 0;
         v.dmem = $urandom_range(0, 29) == 0;
         v.stall = $urandom_range(0, 3) == 0;
         v.start = m_run ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) == 0);
         exp_r = 1'b0;
         if (m_run) begin
            m_cyc++;
            if (!v.stall) begin
               f = v.imem ? 3'd3 : !v.valid ? 3'd4 : v.dmem ? 3'd3 : v.icode == 0 ? 3'd2 : 3'd1;
               if (f != 1) begin
                  m_run = 0; m_stat = f;
               end else begin
                  exp_r = 1'b1;
                  m_ins++;
                  m_pc = v.icode == 8 ? v.valc : v.icode == 9 ? v.valm :
                         (v.icode == 7 && v.cnd) ? v.valc : v.valp;
               end
            end
         end else if (v.start) begin
            m_run = 1; m_pc = 0; m_stat = 1; m_cyc = 0; m_ins = 0;
         end
         apply(v, r);
         check($sformatf("rand%0d pc", n), pc, m_pc);
         check($sformatf("rand%0d ctl", n), {r, stat, fetch_en, cyc, ins},
               {exp_r, m_stat, m_run, m_cyc, m_ins});
      end

`ifdef PC_BREAKPOINT_EN
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      do_start();
      bp_addr = 64'd10;
      bp_en = 1'b1;
      apply(mk(4'h3, 0, 10, 0, 0, 0), r);
      check("bp pre pc", {pc, r}, {64'd10, 1'b1});
      apply(mk(4'h3, 0, 20, 0, 0, 0), r);
      check("bp hit", {brk, fetch_en, r, stat, ins}, {1'b1, 1'b0, 1'b0, 3'd1, 4'd1});
      check("bp hit pc", pc, 10);
      v = mk(4'h3, 0, 20, 0, 0, 0);
      v.start = 1'b1;
      apply(v, r);
      check("bp resume", {brk, fetch_en, pc}, {1'b0, 1'b1, 64'd10});
      apply(mk(4'h3, 0, 20, 0, 0, 0), r);
      check("bp step", {brk, r, pc, ins}, {1'b0, 1'b1, 64'd20, 4'd2});
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
